// File: rtl/cn_accel_pkg.sv
// rtl/cn_accel_pkg.sv - shared constants, state types and decode helpers for the CN-R accelerator
package cn_accel_pkg;

  localparam logic [9:0] CODE_BASE = 10'h000;
  localparam logic [9:0] H0_BASE   = 10'h100;
  localparam logic [9:0] CTRL_BASE = 10'h200;

  localparam int CODE_WORDS    = 140;
  localparam int H0_WORDS      = 28;
  localparam int CODE_INSNS    = CODE_WORDS / 2;
  localparam int H0_QWORDS     = H0_WORDS / 2;
  localparam int SP_DATA_WIDTH = 128;
  localparam int ML_ITERATIONS = 64;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fsm_state_t;
  typedef enum logic [1:0] {ML_IDLE, ML_READ, ML_WRITE} ml_state_t;

  function automatic logic is_code(input logic [9:0] a);
    return a < (CODE_BASE + 10'(CODE_WORDS));
  endfunction

  function automatic logic is_h0(input logic [9:0] a);
    return (a >= H0_BASE) && (a < (H0_BASE + 10'(H0_WORDS)));
  endfunction

endpackage

// File: rtl/cn_ml.sv
// rtl/cn_ml.sv - main-loop engine: read-mix-write rounds over the scratchpad driven by h0 and the code RAM
module cn_ml
  import cn_accel_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 15,
  parameter int ITERATIONS    = ML_ITERATIONS
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  output logic                              sts_running,
  output logic                              finished,
  input  logic [H0_QWORDS-1:0][63:0]        h0,
  output logic [6:0]                        code_addr,
  input  logic [63:0]                       code_data,
  output logic [ADDRESS_WIDTH+1:0]          mem_address,
  output logic [SP_DATA_WIDTH-1:0]          mem_wrdata,
  input  logic [SP_DATA_WIDTH-1:0]          mem_rddata,
  output logic                              mem_write
);

  logic [127:0] ax0, bx0, bx1;
  logic [127:0] ax_q, bx_q, bx1_q, c;
  logic [3:0][31:0] r_q;
  logic [15:0] iter_q;
  logic [6:0] pc_q;
  logic last;
  ml_state_t state_q, state_d;

  assign ax0 = {h0[1] ^ h0[5], h0[0] ^ h0[4]};
  assign bx0 = {h0[3] ^ h0[7], h0[2] ^ h0[6]};
  assign bx1 = {h0[9] ^ h0[11], h0[8] ^ h0[10]};

  // Each round: one cycle to fetch the line addressed by ax, one to write the mixed line back.
  assign last        = (iter_q == 16'(ITERATIONS - 1));
  assign c           = mem_rddata ^ ax_q ^ r_q;
  assign mem_address = ax_q[ADDRESS_WIDTH+5:4];
  assign mem_wrdata  = bx_q ^ bx1_q ^ c;
  assign code_addr   = pc_q;
  assign sts_running = (state_q != ML_IDLE);

  always_comb begin
    state_d   = state_q;
    finished  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      ML_IDLE:  if (start) state_d = ML_READ;
      ML_READ:  state_d = ML_WRITE;
      ML_WRITE: begin
        mem_write = 1'b1;
        if (last) begin
          finished = 1'b1;
          state_d  = ML_IDLE;
        end else begin
          state_d = ML_READ;
        end
      end
      default:  state_d = ML_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ML_IDLE;
      ax_q    <= '0;
      bx_q    <= '0;
      bx1_q   <= '0;
      r_q     <= '0;
      iter_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ML_IDLE && start) begin
        ax_q   <= ax0;
        bx_q   <= bx0;
        bx1_q  <= bx1;
        r_q    <= {h0[13], h0[12]};
        iter_q <= '0;
        pc_q   <= '0;
      end else if (state_q == ML_WRITE) begin
        ax_q   <= ax_q + {c[63:0], c[127:64]};
        bx1_q  <= bx_q;
        bx_q   <= c;
        r_q[0] <= r_q[0] + code_data[31:0];
        r_q[1] <= r_q[1] ^ code_data[63:32];
        r_q[2] <= r_q[2] + r_q[0];
        r_q[3] <= r_q[3] ^ r_q[1];
        iter_q <= iter_q + 16'd1;
        pc_q   <= (pc_q == 7'(CODE_INSNS - 1)) ? 7'd0 : pc_q + 7'd1;
      end
    end
  end

endmodule

// File: rtl/cn_accel_top.sv
// rtl/cn_accel_top.sv - CN-R accelerator wrapper: register bank, scratchpad, control FSM and engine
module cn_accel_top
  import cn_accel_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 15
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDRESS_WIDTH+1:0]   mem_address,
  input  logic                       mem_write,
  input  logic [SP_DATA_WIDTH-1:0]   mem_wrdata,
  output logic [SP_DATA_WIDTH-1:0]   mem_rddata,
  output logic                       sts_ml_finished,
  input  logic [9:0]                 reg_address,
  input  logic                       reg_write,
  input  logic [31:0]                reg_wrdata,
  output logic [31:0]                reg_rddata
);

  localparam int SP_ENTRIES = 1 << (ADDRESS_WIDTH + 2);

  fsm_state_t state_q, state_d;
  logic launch, start_req, running, host_owns;
  logic ml_start_q, finished_q, ml_running, ml_finished;
  logic [31:0] code_q [CODE_WORDS];
  logic [31:0] h0_q [H0_WORDS];
  logic [H0_QWORDS-1:0][63:0] h0_bus;
  logic [6:0] code_addr;
  logic [63:0] code_data;
  logic [31:0] rd_mux;
  logic [ADDRESS_WIDTH+1:0] ml_address, ram_address;
  logic [SP_DATA_WIDTH-1:0] ml_wrdata, ram_wrdata, ram_q;
  logic ml_write, ram_write;
  logic [SP_DATA_WIDTH-1:0] ram [SP_ENTRIES];

  assign start_req = reg_write && (reg_address == CTRL_BASE) && reg_wrdata[0];
  assign running   = (state_q == ST_RUN);
  assign host_owns = !running && !ml_running;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_req) begin
        state_d = ST_RUN;
        launch  = 1'b1;
      end
      ST_RUN:  if (ml_finished) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ml_start_q <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ml_start_q <= launch;
      if (launch) finished_q <= 1'b0;
      else if (running && ml_finished) finished_q <= 1'b1;
    end
  end

  // Code and h0 words are frozen while the engine owns them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CODE_WORDS; i++) code_q[i] <= '0;
      for (int i = 0; i < H0_WORDS; i++) h0_q[i] <= '0;
    end else if (reg_write && host_owns) begin
      if (is_code(reg_address)) code_q[reg_address[7:0]] <= reg_wrdata;
      if (is_h0(reg_address)) h0_q[reg_address[4:0]] <= reg_wrdata;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (is_code(reg_address)) rd_mux = code_q[reg_address[7:0]];
    else if (is_h0(reg_address)) rd_mux = h0_q[reg_address[4:0]];
    else if (reg_address == CTRL_BASE) rd_mux = {30'b0, finished_q, running};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) reg_rddata <= '0;
    else reg_rddata <= rd_mux;
  end

  always_comb begin
    for (int i = 0; i < H0_QWORDS; i++) h0_bus[i] = {h0_q[2*i+1], h0_q[2*i]};
  end

  assign code_data = {code_q[{code_addr, 1'b1}], code_q[{code_addr, 1'b0}]};

  assign ram_address = host_owns ? mem_address : ml_address;
  assign ram_write   = host_owns ? mem_write : ml_write;
  assign ram_wrdata  = host_owns ? mem_wrdata : ml_wrdata;

  always_ff @(posedge clk) begin
    if (ram_write) ram[ram_address] <= ram_wrdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ram_q <= '0;
    else ram_q <= ram[ram_address];
  end

  assign mem_rddata      = ram_q;
  assign sts_ml_finished = finished_q;

  cn_ml #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .ITERATIONS   (ML_ITERATIONS)
  ) u_ml (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (ml_start_q),
    .sts_running(ml_running),
    .finished   (ml_finished),
    .h0         (h0_bus),
    .code_addr  (code_addr),
    .code_data  (code_data),
    .mem_address(ml_address),
    .mem_wrdata (ml_wrdata),
    .mem_rddata (ram_q),
    .mem_write  (ml_write)
  );

endmodule

// File: tb/tb_cn_accel_top.sv
// tb/tb_cn_accel_top.sv - directed self-checking bench for cn_accel_top
module tb_cn_accel_top;
  import cn_accel_pkg::*;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW+1:0] mem_address = '0;
  logic          mem_write = 1'b0;
  logic [127:0]  mem_wrdata = '0;
  logic [127:0]  mem_rddata;
  logic          sts_ml_finished;
  logic [9:0]    reg_address = '0;
  logic          reg_write = 1'b0;
  logic [31:0]   reg_wrdata = '0;
  logic [31:0]   reg_rddata;

  int n_checks = 0;
  int n_pass = 0;

  cn_accel_top #(.ADDRESS_WIDTH(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_address    (mem_address),
    .mem_write      (mem_write),
    .mem_wrdata     (mem_wrdata),
    .mem_rddata     (mem_rddata),
    .sts_ml_finished(sts_ml_finished),
    .reg_address    (reg_address),
    .reg_write      (reg_write),
    .reg_wrdata     (reg_wrdata),
    .reg_rddata     (reg_rddata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [9:0] a, input logic [31:0] d);
    reg_address = a;
    reg_wrdata  = d;
    reg_write   = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    reg_address = a;
    tick();
    check(tag, {96'b0, reg_rddata}, {96'b0, exp});
  endtask

  task automatic mem_wr(input logic [AW+1:0] a, input logic [127:0] d);
    mem_address = a;
    mem_wrdata  = d;
    mem_write   = 1'b1;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic mem_chk(input string tag, input logic [AW+1:0] a, input logic [127:0] exp);
    mem_address = a;
    tick();
    check(tag, mem_rddata, exp);
  endtask

  task automatic wait_finish(input string tag);
    for (int i = 0; i < 2000 && !sts_ml_finished; i++) tick();
    check(tag, {127'b0, sts_ml_finished}, 128'd1);
  endtask

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    check("rst_reg_rddata", {96'b0, reg_rddata}, 128'd0);
    check("rst_mem_rddata", mem_rddata, 128'd0);
    check("rst_finished", {127'b0, sts_ml_finished}, 128'd0);
    reg_chk("rst_ctrl", CTRL_BASE, 32'h0);

    reg_wr(10'h100, 32'h61833732);
    reg_wr(10'h101, 32'h88622535);
    reg_chk("reg_h0_lo", 10'h100, 32'h61833732);
    reg_chk("reg_h0_hi", 10'h101, 32'h88622535);
    reg_chk("reg_unmapped", 10'h300, 32'h0);

    mem_wr(17'h0, {64'h1, 64'h0});
    mem_wr(17'h1FFFF, {128{1'b1}});
    mem_chk("sp_top", 17'h1FFFF, {128{1'b1}});
    mem_chk("sp_zero", 17'h0, {64'h1, 64'h0});

    // Both ports strobed in the same cycle.
    reg_address = 10'h000; reg_wrdata = 32'h0badc0de; reg_write = 1'b1;
    mem_address = 17'h5; mem_wrdata = {4{32'h5a5a1234}}; mem_write = 1'b1;
    tick();
    reg_write = 1'b0; mem_write = 1'b0;
    tick();
    check("dual_reg", {96'b0, reg_rddata}, 128'h0badc0de);
    check("dual_mem", mem_rddata, {4{32'h5a5a1234}});

    reg_wr(10'h108, 32'h1d45e2aa);
    reg_wr(10'h109, 32'ha3def0f4);
    reg_wr(CTRL_BASE, 32'h1);
    reg_address = CTRL_BASE;
    mem_address = 17'h0; mem_wrdata = {128{1'b1}}; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    check("start_ctrl", {96'b0, reg_rddata}, 128'h1);
    check("start_ax0", dut.u_ml.ax0, 128'h2bbcd5c17cc6d598);
    check("run_mem_blocked", dut.ram[0], {64'h1, 64'h0});
    reg_wr(10'h100, 32'hdeadbeef);

    wait_finish("finish_1");
    reg_chk("done_ctrl", CTRL_BASE, 32'h2);
    reg_chk("run_reg_blocked", 10'h100, 32'h61833732);

    reg_wr(CTRL_BASE, 32'h1);
    reg_chk("restart_ctrl", CTRL_BASE, 32'h1);
    check("restart_finished", {127'b0, sts_ml_finished}, 128'd0);

    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    check("abort_reg", {96'b0, reg_rddata}, 128'd0);
    check("abort_mem", mem_rddata, 128'd0);
    check("abort_finished", {127'b0, sts_ml_finished}, 128'd0);
    check("abort_idle", {126'b0, dut.state_q}, {126'b0, ST_IDLE});
    tick();
    reset_n = 1'b1;
    reg_chk("abort_h0_cleared", 10'h100, 32'h0);

    reg_wr(CTRL_BASE, 32'h1);
    reg_chk("after_abort_run", CTRL_BASE, 32'h1);
    wait_finish("finish_2");
    reg_chk("after_abort_done", CTRL_BASE, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
